cordic_fix2dbl: RTL and testbench

Fixed-point to IEEE-754 double converter that sits directly downstream of the 54-stage CORDIC engine in the FPU. It captures the engine's signed fixed-point X/Y results and signed phase, and converts them sequentially through one shared normalize/round datapath. X/Y are converted directly; the phase is first scaled from turns to radians. It produces three binary64 values for the FPU result mux.

---
 rtl/cordic_fix2dbl.sv | 161 ++++++++++++++++
 tb/tb_cordic_fix2dbl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_fix2dbl.sv
// Converts CORDIC X/Y (Q1.52) and phase (fraction of a turn, scaled to radians)
// into binary64 values, one operand per cycle through a single normalizer.
module cordic_fix2dbl #(
    parameter int          IW      = 54,
    parameter int          PW      = 60,
    parameter logic [52:0] TWOPI_M = 53'h1921FB54442D18
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          ld,
    input  logic [IW-1:0] xval_i,
    input  logic [IW-1:0] yval_i,
    input  logic [PW-1:0] phase_i,
    output logic          busy,
    output logic          done,
    output logic [63:0]   xdbl_o,
    output logic [63:0]   ydbl_o,
    output logic [63:0]   phdbl_o
);
    localparam int MW = PW + 53;
    localparam int LW = $clog2(MW);
    localparam logic [10:0] F_XY = 11'd52;
    localparam logic [10:0] F_PH = 11'd110;

    typedef enum logic [2:0] {IDLE, MUL, CX, CY, CP} state_t;

    state_t        state_q, state_d;
    logic          xs_q, xs_d, ys_q, ys_d, ps_q, ps_d;
    logic [IW-1:0] xm_q, xm_d, ym_q, ym_d;
    logic [PW-1:0] pm_q, pm_d;
    logic [MW-1:0] prod_q, prod_d;
    logic [63:0]   xdbl_q, xdbl_d, ydbl_q, ydbl_d, phdbl_q, phdbl_d;
    logic          done_q, done_d;

    // shared normalizer signals
    logic [MW-1:0] nm, norm;
    logic [10:0]   nf, nexp, nexp_r;
    logic          nsign, guard, sticky, inc, carry;
    logic [LW-1:0] lead, shamt;
    logic [51:0]   frac, frac_r;
    logic [63:0]   nres;

    always_comb begin
        nm    = '0;
        nf    = F_XY;
        nsign = 1'b0;
        case (state_q)
            CX: begin
                nm    = {{(MW-IW){1'b0}}, xm_q};
                nsign = xs_q;
            end
            CY: begin
                nm    = {{(MW-IW){1'b0}}, ym_q};
                nsign = ys_q;
            end
            CP: begin
                nm    = prod_q;
                nf    = F_PH;
                nsign = ps_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        lead = '0;
        for (int i = 0; i < MW; i++)
            if (nm[i]) lead = LW'(i);
        shamt  = LW'(MW-1) - lead;
        norm   = nm << shamt;
        frac   = norm[MW-2 -: 52];
        guard  = norm[MW-54];
        sticky = |norm[MW-55:0];
        inc    = guard & (sticky | frac[0]);
        {carry, frac_r} = {1'b0, frac} + {52'b0, inc};
        nexp   = 11'd1023 + {{(11-LW){1'b0}}, lead} - nf;
        nexp_r = nexp + {10'b0, carry};
        // the normalized MSB is set exactly when the operand is nonzero
        nres   = norm[MW-1] ? {nsign, nexp_r, frac_r} : 64'h0;
    end

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        ps_d    = ps_q;
        xm_d    = xm_q;
        ym_d    = ym_q;
        pm_d    = pm_q;
        prod_d  = prod_q;
        xdbl_d  = xdbl_q;
        ydbl_d  = ydbl_q;
        phdbl_d = phdbl_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (ld) begin
                xs_d    = xval_i[IW-1];
                ys_d    = yval_i[IW-1];
                ps_d    = phase_i[PW-1];
                xm_d    = xval_i[IW-1] ? -xval_i : xval_i;
                ym_d    = yval_i[IW-1] ? -yval_i : yval_i;
                pm_d    = phase_i[PW-1] ? -phase_i : phase_i;
                state_d = MUL;
            end
            MUL: begin
                prod_d  = {{(MW-PW){1'b0}}, pm_q} * {{(MW-53){1'b0}}, TWOPI_M};
                state_d = CX;
            end
            CX: begin
                xdbl_d  = nres;
                state_d = CY;
            end
            CY: begin
                ydbl_d  = nres;
                state_d = CP;
            end
            CP: begin
                phdbl_d = nres;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xs_q    <= 1'b0;
            ys_q    <= 1'b0;
            ps_q    <= 1'b0;
            xm_q    <= '0;
            ym_q    <= '0;
            pm_q    <= '0;
            prod_q  <= '0;
            xdbl_q  <= 64'h0;
            ydbl_q  <= 64'h0;
            phdbl_q <= 64'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            ps_q    <= ps_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            pm_q    <= pm_d;
            prod_q  <= prod_d;
            xdbl_q  <= xdbl_d;
            ydbl_q  <= ydbl_d;
            phdbl_q <= phdbl_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign xdbl_o  = xdbl_q;
    assign ydbl_o  = ydbl_q;
    assign phdbl_o = phdbl_q;
endmodule

// File: tb/tb_cordic_fix2dbl.sv
// Scoreboard bench for cordic_fix2dbl: X/Y expectations from real arithmetic,
// phase expectations from an exact shift-right/round-to-nearest-even model.
module tb_cordic_fix2dbl;
    localparam logic [52:0] TWOPI = 53'h1921FB54442D18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld  = 1'b0;
    logic [53:0] xval = '0, yval = '0;
    logic [59:0] phase = '0;
    logic        busy, done;
    logic [63:0] xdbl, ydbl, phdbl;

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] p;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    cordic_fix2dbl dut (
        .rst(rst), .clk(clk), .ld(ld),
        .xval_i(xval), .yval_i(yval), .phase_i(phase),
        .busy(busy), .done(done),
        .xdbl_o(xdbl), .ydbl_o(ydbl), .phdbl_o(phdbl)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fix_dbl(input logic [53:0] v);
        longint vi;
        real    r;
        vi = {{10{v[53]}}, v};
        r  = real'(vi) / 4503599627370496.0;
        return $realtobits(r);
    endfunction

    function automatic logic [63:0] ph_dbl(input logic [59:0] p);
        logic [59:0]  mag;
        logic [112:0] m;
        int           e;
        logic         g, s;
        logic [10:0]  ex;
        mag = p[59] ? (~p + 60'd1) : p;
        m   = {53'b0, mag} * {60'b0, TWOPI};
        if (m == 0) return 64'h0;
        e = -110; g = 1'b0; s = 1'b0;
        while (m[112:53] != 0) begin
            s = s | g;
            g = m[0];
            m = m >> 1;
            e++;
        end
        if (g && (s || m[0])) m = m + 1;
        if (m[53]) begin
            m = m >> 1;
            e++;
        end
        ex = 11'(1023 + 52 + e);
        return {p[59], ex, m[51:0]};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("xdbl", xdbl, e.x);
                check("ydbl", ydbl, e.y);
                check("phdbl", phdbl, e.p);
                check("busy_in_done", 64'(busy), 64'h0);
            end
        end
    end

    // caller sits at a negedge; ld is sampled at the next posedge
    task automatic start(input logic [53:0] x, input logic [53:0] y, input logic [59:0] p, input bit push);
        xval = x; yval = y; phase = p; ld = 1'b1;
        if (push) sb.push_back('{fix_dbl(x), fix_dbl(y), ph_dbl(p)});
        @(negedge clk);
        ld    = 1'b0;
        xval  = 54'($urandom);
        yval  = 54'($urandom);
        phase = 60'($urandom);
    endtask

    task automatic wait_done();
        int n0;
        n0 = n_done;
        for (int i = 0; i < 20 && n_done == n0; i++) @(posedge clk);
        check("done_timeout", 64'(n_done - n0), 64'd1);
        @(negedge clk);
    endtask

    logic [59:0] sp_ph [8] = '{60'h1, 60'h3, 60'h5, 60'hFFFFFFFFFFFFFFF,
                              60'hFFFFFFFFFFFFFFD, 60'h7FFFFFFFFFFFFFF,
                              60'h800000000000000, 60'h400000000000000};
    logic [53:0] sp_xy [4] = '{54'h1, 54'h3FFFFFFFFFFFFF, 54'h1FFFFFFFFFFFFF, 54'h20000000000000};

    initial begin
        int n0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_x", xdbl, 64'h0);
        check("rst_y", ydbl, 64'h0);
        check("rst_ph", phdbl, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // latency of the first conversion, edge by edge
        start(54'h10000000000000, 54'h0, 60'h0, 1'b1);
        check("t1_busy", 64'(busy), 64'h1);
        check("t1_done", 64'(done), 64'h0);
        @(negedge clk);
        check("t2_x_early", xdbl, 64'h0);
        @(negedge clk);
        check("t3_x", xdbl, 64'h3FF0000000000000);
        check("t3_done", 64'(done), 64'h0);
        @(negedge clk);
        check("t4_done", 64'(done), 64'h0);
        @(negedge clk);
        check("t5_done", 64'(done), 64'h1);
        check("t5_busy", 64'(busy), 64'h0);
        check("t5_y", ydbl, 64'h0);
        check("t5_ph", phdbl, 64'h0);
        @(negedge clk);
        check("t6_done", 64'(done), 64'h0);

        start(54'h20000000000000, 54'h1FFFFFFFFFFFFF, 60'h400000000000000, 1'b1);
        wait_done();
        check("x_neg2", xdbl, 64'hC000000000000000);
        check("y_max", ydbl, 64'h3FFFFFFFFFFFFFFF);
        check("ph_halfpi", phdbl, 64'h3FF921FB54442D18);
        start(54'h0, 54'h0, 60'h800000000000000, 1'b1);
        wait_done();
        check("ph_negpi", phdbl, 64'hC00921FB54442D18);
        start(54'h0, 54'h0, 60'h1, 1'b1);
        wait_done();
        check("ph_lsb", phdbl, 64'h3C5921FB54442D18);

        // ld while busy is ignored
        n0 = n_done;
        start(54'h08000000000000, 54'h3FFFFFFFFFFFFF, 60'h5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            xval = 54'h1; yval = 54'h2; phase = 60'h3; ld = 1'b1;
            @(negedge clk);
        end
        ld = 1'b0;
        repeat (10) @(negedge clk);
        check("single_done", 64'(n_done - n0), 64'd1);

        // back-to-back: ld during done cycle
        start(54'h2AAAAAAAAAAAAA, 54'h15555555555555, 60'h123456789ABCDEF, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_done_a", 64'(done), 64'h1);
        start(54'h3, 54'h20000000000001, 60'hFEDCBA987654321, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_done_b", 64'(done), 64'h1);
        @(negedge clk);

        // reset mid-conversion
        start(54'h10000000000000, 54'h10000000000000, 60'h400000000000000, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_x", xdbl, 64'h0);
        check("mrst_y", ydbl, 64'h0);
        check("mrst_ph", phdbl, 64'h0);
        check("mrst_busy", 64'(busy), 64'h0);
        check("mrst_done", 64'(done), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        start(54'h30000000000000, 54'h08000000000000, 60'h200000000000000, 1'b1);
        wait_done();

        for (int i = 0; i < 300; i++) begin
            logic [63:0] rx, ry, rp;
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            rp = {$urandom, $urandom};
            if (i < 8) rp[59:0] = sp_ph[i];
            if (i < 4) begin
                rx[53:0] = sp_xy[i];
                ry[53:0] = sp_xy[3-i];
            end
            if (i % 7 == 3) rp[59:0] = 60'(rp[7:0]);
            start(rx[53:0], ry[53:0], rp[59:0], 1'b1);
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
